reg_wb_queue: RTL and testbench

//   Write-side driver for the 32x32 register file: buffers completed results (rd, data) from execute/load,

---
 rtl/reg_wb_queue.sv | 108 ++++++++++
 tb/tb_reg_wb_queue.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the register file write port, with RAW hazard flags for decode.
// Optional forwarding of the youngest pending value is enabled by defining REG_WB_FWD_EN.
module reg_wb_queue #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDRESS_WIDTH-1:0]     in_rd,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [ADDRESS_WIDTH-1:0]     ad1,
  input  logic [ADDRESS_WIDTH-1:0]     ad2,
  output logic                         hazard1,
  output logic                         hazard2,
  output logic                         WE3,
  output logic [ADDRESS_WIDTH-1:0]     ad3,
  output logic [DATA_WIDTH-1:0]        WD3,
  output logic [$clog2(DEPTH):0]       count
`ifdef REG_WB_FWD_EN
  ,
  output logic [DATA_WIDTH-1:0]        fwd1,
  output logic [DATA_WIDTH-1:0]        fwd2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic [ADDRESS_WIDTH-1:0] w_head_rd;
  logic [DATA_WIDTH-1:0]    w_head_data;

  assign w_empty     = (r_count == {CNT_W{1'b0}});
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_push      = in_valid && !w_full;
  assign w_pop       = !w_empty;
  assign w_head_rd   = r_rd[r_rd_ptr];
  assign w_head_data = r_data[r_rd_ptr];

  // Queue storage, pointers and occupancy; the head drains every non-empty cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_rd[r_wr_ptr]   <= in_rd;
        r_data[r_wr_ptr] <= in_data;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready = !w_full;
  assign count    = r_count;
  // x0 entries still drain but never write; nothing is written on a reset edge.
  assign WE3      = !rst && !w_empty && (w_head_rd != {ADDRESS_WIDTH{1'b0}});
  assign ad3      = w_empty ? {ADDRESS_WIDTH{1'b0}} : w_head_rd;
  assign WD3      = w_empty ? {DATA_WIDTH{1'b0}} : w_head_data;

  // Hazard scan over every occupied slot, head included.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      hazard1 = hazard1 | ((CNT_W'(k) < r_count) && (ad1 != {ADDRESS_WIDTH{1'b0}}) &&
                           (r_rd[r_rd_ptr + PTR_W'(k)] == ad1));
      hazard2 = hazard2 | ((CNT_W'(k) < r_count) && (ad2 != {ADDRESS_WIDTH{1'b0}}) &&
                           (r_rd[r_rd_ptr + PTR_W'(k)] == ad2));
    end
  end

`ifdef REG_WB_FWD_EN
  // Oldest-to-youngest scan, so the last match left standing is the youngest entry.
  always_comb begin
    fwd1 = {DATA_WIDTH{1'b0}};
    fwd2 = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      fwd1 = ((CNT_W'(k) < r_count) && (ad1 != {ADDRESS_WIDTH{1'b0}}) &&
              (r_rd[r_rd_ptr + PTR_W'(k)] == ad1)) ? r_data[r_rd_ptr + PTR_W'(k)] : fwd1;
      fwd2 = ((CNT_W'(k) < r_count) && (ad2 != {ADDRESS_WIDTH{1'b0}}) &&
              (r_rd[r_rd_ptr + PTR_W'(k)] == ad2)) ? r_data[r_rd_ptr + PTR_W'(k)] : fwd2;
    end
  end
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed scenarios plus random traffic,
// each cycle compared against a queue-based reference model.
module tb_reg_wb_queue;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;
  logic [AW-1:0] ad1;
  logic [AW-1:0] ad2;
  logic          hazard1;
  logic          hazard2;
  logic          WE3;
  logic [AW-1:0] ad3;
  logic [DW-1:0] WD3;
  logic [2:0]    count;
`ifdef REG_WB_FWD_EN
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
`endif

  reg_wb_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_data(in_data), .ad1(ad1), .ad2(ad2),
    .hazard1(hazard1), .hazard2(hazard2), .WE3(WE3), .ad3(ad3), .WD3(WD3),
    .count(count)
`ifdef REG_WB_FWD_EN
    , .fwd1(fwd1), .fwd2(fwd2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_writes = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard(input logic [AW-1:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] model_fwd(input logic [AW-1:0] a);
    logic [DW-1:0] v = 32'd0;
    if (a == 5'd0) return 32'd0;
    foreach (q[i]) if (q[i].rd == a) v = q[i].data;
    return v;
  endfunction

  // One clock cycle: apply inputs, check mid-cycle against the model, then advance the model.
  task automatic cycle(input bit r, input bit v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2, input bit do_chk);
    bit pushed;
    rst = r; in_valid = v; in_rd = rd; in_data = d; ad1 = a1; ad2 = a2;
    #4;
    if (do_chk) begin
      chk("count", DW'(count), DW'(q.size()));
      chk("in_ready", DW'(in_ready), DW'(q.size() != DEPTH));
      chk("WE3", DW'(WE3), DW'(!r && q.size() > 0 && q[0].rd != 5'd0));
      chk("ad3", DW'(ad3), (q.size() > 0) ? DW'(q[0].rd) : 32'd0);
      chk("WD3", WD3, (q.size() > 0) ? q[0].data : 32'd0);
      chk("hazard1", DW'(hazard1), DW'(model_hazard(a1)));
      chk("hazard2", DW'(hazard2), DW'(model_hazard(a2)));
`ifdef REG_WB_FWD_EN
      chk("fwd1", fwd1, model_fwd(a1));
      chk("fwd2", fwd2, model_fwd(a2));
`endif
      if (WE3) n_writes++;
    end
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      pushed = v && (q.size() < DEPTH);
      if (q.size() > 0) void'(q.pop_front());
      if (pushed) q.push_back('{rd: rd, data: d});
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_data = 32'd0; ad1 = 5'd0; ad2 = 5'd0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);

    // Reset asserted for two cycles in the middle of a push stream
    cycle(1'b0, 1'b1, 5'd7, 32'h0000_0077, 5'd7, 5'd0, 1'b1);
    cycle(1'b0, 1'b1, 5'd8, 32'h0000_0088, 5'd7, 5'd8, 1'b1);
    cycle(1'b1, 1'b1, 5'd9, 32'h0000_0099, 5'd8, 5'd9, 1'b1);
    cycle(1'b1, 1'b1, 5'd9, 32'h0000_0099, 5'd8, 5'd9, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd9, 1'b1);

    // Single push rd=10, then drain
    cycle(1'b0, 1'b1, 5'd10, 32'h0000_1234, 5'd10, 5'd0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0, 1'b1);

    // Back-to-back pushes rd 1..5 with the producer held valid
    for (int i = 1; i <= 5; i++)
      cycle(1'b0, 1'b1, AW'(i), 32'h1000_0000 + DW'(i), AW'(i), AW'(i + 1), 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd4, 1'b1);

    // x0 write is consumed without a regfile write
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);

    // Repeated writes to rd=5 with decode reading 5 and 6
    cycle(1'b0, 1'b1, 5'd5, 32'h0000_000A, 5'd5, 5'd6, 1'b1);
    cycle(1'b0, 1'b1, 5'd5, 32'h0000_000B, 5'd5, 5'd6, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 1'b1);

    // Random traffic with small register range to provoke hazards and x0 entries
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            AW'($urandom_range(0, 7)), DW'($urandom()),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);

    checks++;
    assert (n_writes > 100) else begin
      errors++;
      $error("FAIL write_activity observed=%0d expected=>100", n_writes);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
